// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing driver: axis region encoding,
// default 640x480@60 timing constants and the colour-bar table used by the
// optional test pattern (VGA_TEST_PATTERN_EN).
package vga_pkg;

    // Region order along each axis, starting from count 0
    typedef enum logic [1:0] {
        SYNC        = 2'd0,
        BACK_PORCH  = 2'd1,
        ACTIVE      = 2'd2,
        FRONT_PORCH = 2'd3
    } region_e;

    // Default 640x480@60 timing with a 25 MHz pixel rate from a 50 MHz clock
    localparam int DEF_CLK_DIV = 2;
    localparam int DEF_COLOR_W = 4;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BP    = 48;
    localparam int DEF_H_ACT   = 640;
    localparam int DEF_H_FP    = 16;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BP    = 33;
    localparam int DEF_V_ACT   = 480;
    localparam int DEF_V_FP    = 10;

    // Colour bars, left to right: white, yellow, cyan, green, magenta, red,
    // blue, black. Each entry is {r,g,b}; bar 0 sits in the least significant slot.
    localparam int NUM_BARS = 8;
    localparam logic [7:0][2:0] BAR_TABLE = {
        3'b000,   // 7 black
        3'b001,   // 6 blue
        3'b100,   // 5 red
        3'b101,   // 4 magenta
        3'b010,   // 3 green
        3'b011,   // 2 cyan
        3'b110,   // 1 yellow
        3'b111    // 0 white
    };

    // Look up the {r,g,b} on/off bits of one colour bar
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        bar_rgb = BAR_TABLE[idx];
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis (horizontal or vertical) of the VGA raster: a wrapping counter
// over SYNC, BACK_PORCH, ACTIVE and FRONT_PORCH, reporting the region of the
// current count and a wrap strobe used to step the next axis.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int SYNC_LEN = DEF_H_SYNC,
    parameter int BP_LEN   = DEF_H_BP,
    parameter int ACT_LEN  = DEF_H_ACT,
    parameter int FP_LEN   = DEF_H_FP,
    parameter int TOTAL    = SYNC_LEN + BP_LEN + ACT_LEN + FP_LEN,
    parameter int CW       = $clog2(TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    output logic [CW-1:0] count,
    output region_e       region,
    output logic          wrap
);

    if (SYNC_LEN < 1 || BP_LEN < 1 || ACT_LEN < 1 || FP_LEN < 1) begin : g_bad_timing
        $error("vga_axis_counter: every timing parameter must be non-zero");
    end

    localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] BP_START  = CW'(SYNC_LEN);
    localparam logic [CW-1:0] ACT_START = CW'(SYNC_LEN + BP_LEN);
    localparam logic [CW-1:0] FP_START  = CW'(SYNC_LEN + BP_LEN + ACT_LEN);

    logic [CW-1:0] count_r;
    region_e       region_s;

    // Position counter: advances on step, wraps from the last count to 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (step) begin
            if (count_r == LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + ONE;
            end
        end
    end

    // Decode the region the current count falls in
    always_comb begin
        region_s = SYNC;
        if (count_r < BP_START) begin
            region_s = SYNC;
        end else if (count_r < ACT_START) begin
            region_s = BACK_PORCH;
        end else if (count_r < FP_START) begin
            region_s = ACTIVE;
        end else begin
            region_s = FRONT_PORCH;
        end
    end

    assign count  = count_r;
    assign region = region_s;
    assign wrap   = step && (count_r == LAST);

endmodule

// File: rtl/vga_timing_driver.sv
// Programmable VGA timing generator: pixel-rate divider, H/V raster counters,
// pixel coordinates for the upstream source and a registered sync/colour
// output stage with blanking. Optional colour-bar test pattern is compiled
// in with the VGA_TEST_PATTERN_EN macro.
module vga_timing_driver
    import vga_pkg::*;
#(
    parameter int   CLK_DIV = DEF_CLK_DIV,
    parameter int   COLOR_W = DEF_COLOR_W,
    parameter int   H_SYNC  = DEF_H_SYNC,
    parameter int   H_BP    = DEF_H_BP,
    parameter int   H_ACT   = DEF_H_ACT,
    parameter int   H_FP    = DEF_H_FP,
    parameter int   V_SYNC  = DEF_V_SYNC,
    parameter int   V_BP    = DEF_V_BP,
    parameter int   V_ACT   = DEF_V_ACT,
    parameter int   V_FP    = DEF_V_FP,
    parameter logic H_POL   = 1'b0,
    parameter logic V_POL   = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [COLOR_W-1:0]        red,
    input  logic [COLOR_W-1:0]        green,
    input  logic [COLOR_W-1:0]        blue,
    input  logic                      test_mode,
    output logic [$clog2(H_ACT)-1:0]  pix_x,
    output logic [$clog2(V_ACT)-1:0]  pix_y,
    output logic                      pix_req,
    output logic                      pix_en,
    output logic                      frame_start,
    output logic [COLOR_W-1:0]        red_,
    output logic [COLOR_W-1:0]        green_,
    output logic [COLOR_W-1:0]        blue_,
    output logic                      h_sync,
    output logic                      v_sync
);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_driver: CLK_DIV must be at least 1");
    end

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACT);
    localparam int YW      = $clog2(V_ACT);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0]  DIV_LAST    = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]  DIV_ONE     = DW'(1);
    localparam logic [HCW-1:0] H_ACT_START = HCW'(H_SYNC + H_BP);
    localparam logic [VCW-1:0] V_ACT_START = VCW'(V_SYNC + V_BP);

    logic [DW-1:0]      div_cnt_r;
    logic [DW-1:0]      div_nxt_s;
    logic               pix_en_r;
    logic [HCW-1:0]     h_cnt_s;
    logic [VCW-1:0]     v_cnt_s;
    region_e            h_region_s;
    region_e            v_region_s;
    logic               h_wrap_s;
    logic               v_wrap_unused_s;
    logic               pix_req_s;
    logic [XW-1:0]      pix_x_s;
    logic [YW-1:0]      pix_y_s;
    logic               tick_origin_s;
    logic               origin_seen_r;
    logic               frame_start_nxt_s;
    logic               frame_start_r;
    logic [COLOR_W-1:0] red_src_s;
    logic [COLOR_W-1:0] green_src_s;
    logic [COLOR_W-1:0] blue_src_s;
    logic [COLOR_W-1:0] red_r;
    logic [COLOR_W-1:0] green_r;
    logic [COLOR_W-1:0] blue_r;
    logic               h_sync_r;
    logic               v_sync_r;

    // Next divider value: counts 0..CLK_DIV-1 and wraps
    always_comb begin
        div_nxt_s = '0;
        if (div_cnt_r == DIV_LAST) begin
            div_nxt_s = '0;
        end else begin
            div_nxt_s = div_cnt_r + DIV_ONE;
        end
    end

    // Divider and pixel enable; pix_en_r is high in the clk where the divider sits at CLK_DIV-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= '0;
            pix_en_r  <= 1'b0;
        end else begin
            div_cnt_r <= div_nxt_s;
            pix_en_r  <= (div_nxt_s == DIV_LAST);
        end
    end

    vga_axis_counter #(
        .SYNC_LEN (H_SYNC),
        .BP_LEN   (H_BP),
        .ACT_LEN  (H_ACT),
        .FP_LEN   (H_FP)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .step   (pix_en_r),
        .count  (h_cnt_s),
        .region (h_region_s),
        .wrap   (h_wrap_s)
    );

    vga_axis_counter #(
        .SYNC_LEN (V_SYNC),
        .BP_LEN   (V_BP),
        .ACT_LEN  (V_ACT),
        .FP_LEN   (V_FP)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .step   (h_wrap_s),
        .count  (v_cnt_s),
        .region (v_region_s),
        .wrap   (v_wrap_unused_s)
    );

    // Active-pixel request and coordinates, forced to 0 outside the active area
    always_comb begin
        pix_req_s = (h_region_s == ACTIVE) && (v_region_s == ACTIVE);
        if (pix_req_s) begin
            pix_x_s = XW'(h_cnt_s - H_ACT_START);
            pix_y_s = YW'(v_cnt_s - V_ACT_START);
        end else begin
            pix_x_s = '0;
            pix_y_s = '0;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACT / NUM_BARS;

    if (BAR_W < 1) begin : g_bad_bars
        $error("vga_timing_driver: H_ACT too small for the colour-bar pattern");
    end

    localparam logic [XW-1:0] BAR_DIV  = XW'((BAR_W < 1) ? 1 : BAR_W);
    localparam logic [XW-1:0] BAR_LAST = XW'(NUM_BARS - 1);

    logic [XW-1:0] bar_q_s;
    logic [2:0]    bar_idx_s;
    logic [2:0]    bar_bits_s;

    // Colour source: colour bars while test_mode is set, upstream RGB otherwise
    always_comb begin
        bar_q_s = pix_x_s / BAR_DIV;
        if (bar_q_s > BAR_LAST) begin
            bar_idx_s = 3'd7;
        end else begin
            bar_idx_s = bar_q_s[2:0];
        end
        bar_bits_s = bar_rgb(bar_idx_s);
        if (test_mode) begin
            red_src_s   = {COLOR_W{bar_bits_s[2]}};
            green_src_s = {COLOR_W{bar_bits_s[1]}};
            blue_src_s  = {COLOR_W{bar_bits_s[0]}};
        end else begin
            red_src_s   = red;
            green_src_s = green;
            blue_src_s  = blue;
        end
    end
`else
    logic test_mode_unused_s;

    assign test_mode_unused_s = test_mode;
    assign red_src_s          = red;
    assign green_src_s        = green;
    assign blue_src_s         = blue;
`endif

    // Output stage: sync levels and blanked colour captured once per pixel tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_sync_r <= ~H_POL;
            v_sync_r <= ~V_POL;
            red_r    <= '0;
            green_r  <= '0;
            blue_r   <= '0;
        end else if (pix_en_r) begin
            h_sync_r <= (h_region_s == SYNC) ? H_POL : ~H_POL;
            v_sync_r <= (v_region_s == SYNC) ? V_POL : ~V_POL;
            if (pix_req_s) begin
                red_r   <= red_src_s;
                green_r <= green_src_s;
                blue_r  <= blue_src_s;
            end else begin
                red_r   <= '0;
                green_r <= '0;
                blue_r  <= '0;
            end
        end
    end

    assign tick_origin_s = pix_en_r && (h_cnt_s == '0) && (v_cnt_s == '0);

    // frame_start is due in the next pix_en clk when the previous tick was at the raster origin
    always_comb begin
        frame_start_nxt_s = 1'b0;
        if (div_nxt_s != DIV_LAST) begin
            frame_start_nxt_s = 1'b0;
        end else if (pix_en_r) begin
            frame_start_nxt_s = tick_origin_s;
        end else begin
            frame_start_nxt_s = origin_seen_r;
        end
    end

    // Remember whether the last pixel tick was the origin and register the frame pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            origin_seen_r <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            if (pix_en_r) begin
                origin_seen_r <= tick_origin_s;
            end
            frame_start_r <= frame_start_nxt_s;
        end
    end

    assign pix_x       = pix_x_s;
    assign pix_y       = pix_y_s;
    assign pix_req     = pix_req_s;
    assign pix_en      = pix_en_r;
    assign frame_start = frame_start_r;
    assign red_        = red_r;
    assign green_      = green_r;
    assign blue_       = blue_r;
    assign h_sync      = h_sync_r;
    assign v_sync      = v_sync_r;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Scoreboard bench for vga_timing_driver on a small raster:
// CLK_DIV=2, H = 3/2/16/2 (23 ticks), V = 2/2/4/1 (9 lines).
// Line = 46 clks, frame = 207 ticks = 414 clks.
module tb_vga_timing_driver;

    localparam int CLK_DIV = 2;
    localparam int H_SYNC = 3, H_BP = 2, H_ACT = 16, H_FP = 2;
    localparam int V_SYNC = 2, V_BP = 2, V_ACT = 4, V_FP = 1;
    localparam int H_TOT = 23;
    localparam int V_TOT = 9;
    localparam int FRAME_TICKS = 207;
    localparam int FRAME_CLKS = 414;
    localparam int HS_CLKS_PER_FRAME = 54;   // 9 lines x 3 ticks x 2 clks
    localparam int VS_CLKS_PER_FRAME = 92;   // 2 lines x 46 clks

    logic       clk;
    logic       reset;
    logic [3:0] red, green, blue;
    logic       test_mode;
    logic [3:0] pix_x;
    logic [1:0] pix_y;
    logic       pix_req, pix_en, frame_start;
    logic [3:0] red_, green_, blue_;
    logic       h_sync, v_sync;

    vga_timing_driver #(
        .CLK_DIV (CLK_DIV), .COLOR_W (4),
        .H_SYNC (H_SYNC), .H_BP (H_BP), .H_ACT (H_ACT), .H_FP (H_FP),
        .V_SYNC (V_SYNC), .V_BP (V_BP), .V_ACT (V_ACT), .V_FP (V_FP),
        .H_POL (1'b0), .V_POL (1'b0)
    ) dut (
        .clk (clk), .reset (reset),
        .red (red), .green (green), .blue (blue), .test_mode (test_mode),
        .pix_x (pix_x), .pix_y (pix_y), .pix_req (pix_req), .pix_en (pix_en),
        .frame_start (frame_start),
        .red_ (red_), .green_ (green_), .blue_ (blue_),
        .h_sync (h_sync), .v_sync (v_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic [3:0] x;
        logic [1:0] y;
        logic       fs;
    } tick_exp_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pin_exp_t;

    tick_exp_t tick_q[$];
    pin_exp_t  pin_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int gn    = 0;   // pixel tick index since last reset release

    logic [11:0] col_tab [4] = '{12'hFFF, 12'h5A3, 12'h1C7, 12'hE08};
    logic [2:0]  bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                 3'b101, 3'b100, 3'b001, 3'b000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pix_en"},      32'(pix_en),      32'd0);
        chk({tag, "_pix_req"},     32'(pix_req),     32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_pix_x"},       32'(pix_x),       32'd0);
        chk({tag, "_pix_y"},       32'(pix_y),       32'd0);
        chk({tag, "_rgb"},         32'({red_, green_, blue_}), 32'd0);
        chk({tag, "_h_sync"},      32'(h_sync),      32'd1);
        chk({tag, "_v_sync"},      32'(v_sync),      32'd1);
    endtask

    // Drive one pixel tick per CLK_DIV clocks and push the expected responses
    task automatic run_ticks(input int n_ticks, input logic tm);
        int h, v;
        logic [11:0] col;
        tick_exp_t te;
        pin_exp_t  pe;
        for (int n = 0; n < n_ticks; n++) begin
            @(posedge clk);
            #1;
            h = gn % H_TOT;
            v = (gn / H_TOT) % V_TOT;
            col = col_tab[gn % 4];
            red = col[11:8]; green = col[7:4]; blue = col[3:0];
            test_mode = tm;
            te.req = (h >= 5) && (h < 21) && (v >= 4) && (v < 8);
            te.x   = te.req ? 4'(h - 5) : 4'd0;
            te.y   = te.req ? 2'(v - 4) : 2'd0;
            te.fs  = (gn > 0) && (((gn - 1) % FRAME_TICKS) == 0);
            pe.hs  = (h < 3) ? 1'b0 : 1'b1;
            pe.vs  = (v < 2) ? 1'b0 : 1'b1;
            if (!te.req) begin
                pe.r = 4'd0; pe.g = 4'd0; pe.b = 4'd0;
            end else if (tm) begin
                pe.r = {4{bar_tab[te.x / 2][2]}};
                pe.g = {4{bar_tab[te.x / 2][1]}};
                pe.b = {4{bar_tab[te.x / 2][0]}};
            end else begin
                pe.r = col[11:8]; pe.g = col[7:4]; pe.b = col[3:0];
            end
            tick_q.push_back(te);
            pin_q.push_back(pe);
            gn++;
            @(posedge clk);
        end
    endtask

    // Monitor: on each pixel tick compare coordinates now and pins for the previous tick
    tick_exp_t mt;
    pin_exp_t  mp;
    always @(negedge clk) begin
        if (reset && pix_en) begin
            if (tick_q.size() == 0) begin
                chk("unexpected_pix_tick", 32'd1, 32'd0);
            end else begin
                mt = tick_q.pop_front();
                chk("pix_req",     32'(pix_req),     32'(mt.req));
                chk("pix_x",       32'(pix_x),       32'(mt.x));
                chk("pix_y",       32'(pix_y),       32'(mt.y));
                chk("frame_start", 32'(frame_start), 32'(mt.fs));
            end
            if (pin_q.size() > 1) begin
                mp = pin_q.pop_front();
                chk("h_sync", 32'(h_sync), 32'(mp.hs));
                chk("v_sync", 32'(v_sync), 32'(mp.vs));
                chk("rgb",    32'({red_, green_, blue_}), 32'({mp.r, mp.g, mp.b}));
            end
        end
    end

    // Pixel-enable cadence: high on every second clk after reset release
    int cyc = 0;
    always @(posedge clk) cyc = reset ? cyc + 1 : 0;
    always @(negedge clk) begin
        if (reset) begin
            chk("pix_en_cadence", 32'(pix_en), 32'((cyc % 2) == 1));
            if (!pix_en) chk("frame_start_off_tick", 32'(frame_start), 32'd0);
        end
    end

    // Frame period and sync duty measured between frame_start pulses
    int  fp_clks = 0, fp_hs = 0, fp_vs = 0;
    logic fp_seen = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            fp_seen = 1'b0;
        end else begin
            if (frame_start) begin
                if (fp_seen) begin
                    chk("frame_period_clks", 32'(fp_clks), 32'(FRAME_CLKS));
                    chk("hsync_clks_frame",  32'(fp_hs),   32'(HS_CLKS_PER_FRAME));
                    chk("vsync_clks_frame",  32'(fp_vs),   32'(VS_CLKS_PER_FRAME));
                end
                fp_seen = 1'b1;
                fp_clks = 0; fp_hs = 0; fp_vs = 0;
            end
            fp_clks++;
            if (h_sync === 1'b0) fp_hs++;
            if (v_sync === 1'b0) fp_vs++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        red = 4'd0; green = 4'd0; blue = 4'd0;
        test_mode = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("init");
        reset = 1'b1;

        // Two full frames plus part of a third, stopping inside the active area (h=9, v=5)
        run_ticks(2 * FRAME_TICKS + 125, 1'b0);

        // Mid-frame reset: outputs clear at once, raster restarts at the origin
        #2;
        reset = 1'b0;
        tick_q.delete();
        pin_q.delete();
        gn = 0;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        fork
            run_ticks(500, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #2;
                chk("vsync_after_release", 32'(v_sync), 32'd0);
            end
        join

`ifdef VGA_TEST_PATTERN_EN
        run_ticks(FRAME_TICKS, 1'b1);
`endif

        #1;
        chk("tick_queue_drained", 32'(tick_q.size()), 32'd0);
        chk("pin_queue_drained",  32'(pin_q.size() <= 1), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
